// File: rtl/shift_right_unit.sv
// shift_right_unit: iterative barrel-free right shifter, one bit per clock.
// A Start seen while idle captures In, Shamt and Arith, then the working
// register is shifted right once per edge until the counter reaches zero.
// The result is then written to Out, and Done pulses for one cycle.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - synchronous, active-high reset
//   Start  - request, sampled only while idle
//   In     - operand, captured on an accepted Start
//   Shamt  - shift distance 0..WIDTH-1, captured on an accepted Start
//   Arith  - 1: sign-fill (arithmetic), 0: zero-fill (logical)
//   Out    - registered result, held until the next Done or Reset
//   Busy   - registered, high while shifting
//   Done   - registered, one-cycle completion pulse
module shift_right_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] In,
  input  logic [SHW-1:0]   Shamt,
  input  logic             Arith,
  output logic [WIDTH-1:0] Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             fill_q,  fill_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    out_d   = out_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          work_d  = In;
          cnt_d   = Shamt;
          // Arith and the operand sign are folded into one fill bit at
          // capture time, so later input changes cannot reach the shifter.
          fill_d  = Arith & In[WIDTH-1];
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != '0) begin
          work_d = {fill_q, work_q[WIDTH-1:1]};
          cnt_d  = cnt_q - SHW'(1);
          busy_d = 1'b1;
        end else begin
          out_d   = work_q;
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Out  = out_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule
